seg7_scan_driver: RTL and testbench

//  Downstream display stage for the airflyer game counters (fire count, score, lives).

---
 rtl/seg7_pkg.sv | 46 ++++
 rtl/seg7_decode.sv | 39 +++
 rtl/seg7_scan_driver.sv | 187 ++++++++++++++++++
 tb/tb_seg7_scan_driver.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment display path: glyphs, scan states, digit buffer layout.
// Pure definitions; no timing or flow control.
package seg7_pkg;

   localparam int MAX_DIGITS = 8;

   // Segment glyphs, active-high, bits 6..0 = g..a, bit 7 (dp) left clear
   localparam logic [7:0] SEG_0     = 8'h3F;
   localparam logic [7:0] SEG_1     = 8'h06;
   localparam logic [7:0] SEG_2     = 8'h5B;
   localparam logic [7:0] SEG_3     = 8'h4F;
   localparam logic [7:0] SEG_4     = 8'h66;
   localparam logic [7:0] SEG_5     = 8'h6D;
   localparam logic [7:0] SEG_6     = 8'h7D;
   localparam logic [7:0] SEG_7     = 8'h07;
   localparam logic [7:0] SEG_8     = 8'h7F;
   localparam logic [7:0] SEG_9     = 8'h6F;
   localparam logic [7:0] SEG_A     = 8'h77;
   localparam logic [7:0] SEG_B     = 8'h7C;
   localparam logic [7:0] SEG_C     = 8'h39;
   localparam logic [7:0] SEG_D     = 8'h5E;
   localparam logic [7:0] SEG_E     = 8'h79;
   localparam logic [7:0] SEG_F     = 8'h71;
   localparam logic [7:0] SEG_BLANK = 8'h00;

   localparam logic [7:0] CAT_OFF   = 8'hFF;

   typedef enum logic [0:0] {
      ST_SHOW = 1'b0,
      ST_GAP  = 1'b1
   } state_e;

   // One display frame worth of data, always sized for the widest display
   typedef struct packed {
      logic [4*MAX_DIGITS-1:0] code;
      logic [MAX_DIGITS-1:0]   dp;
      logic [MAX_DIGITS-1:0]   en;
   } disp_buf_t;

   localparam disp_buf_t BUF_CLEAR = '0;

   function automatic logic [7:0] cat_select(input logic [2:0] idx);
      return ~(8'h01 << idx);
   endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational digit-code to segment decoder with optional hex glyphs and decimal point.
// Zero latency, no flow control.
module seg7_decode
   import seg7_pkg::*;
(
   input  logic [3:0] code,
   input  logic       hex_en,
   input  logic       dp,
   output logic [7:0] seg
);

   logic [7:0] w_glyph;

   always_comb begin
      w_glyph = SEG_BLANK;
      case (code)
         4'h0: w_glyph = SEG_0;
         4'h1: w_glyph = SEG_1;
         4'h2: w_glyph = SEG_2;
         4'h3: w_glyph = SEG_3;
         4'h4: w_glyph = SEG_4;
         4'h5: w_glyph = SEG_5;
         4'h6: w_glyph = SEG_6;
         4'h7: w_glyph = SEG_7;
         4'h8: w_glyph = SEG_8;
         4'h9: w_glyph = SEG_9;
         4'hA: w_glyph = hex_en ? SEG_A : SEG_BLANK;
         4'hB: w_glyph = hex_en ? SEG_B : SEG_BLANK;
         4'hC: w_glyph = hex_en ? SEG_C : SEG_BLANK;
         4'hD: w_glyph = hex_en ? SEG_D : SEG_BLANK;
         4'hE: w_glyph = hex_en ? SEG_E : SEG_BLANK;
         4'hF: w_glyph = hex_en ? SEG_F : SEG_BLANK;
         default: w_glyph = SEG_BLANK;
      endcase
   end

   assign seg = {dp, w_glyph[6:0]};

endmodule

// File: rtl/seg7_scan_driver.sv
// Double-buffered multiplexed 7-segment driver; outputs registered, new data lands at frame wrap.
// No backpressure: load is always accepted, last load before a commit wins.
module seg7_scan_driver
   import seg7_pkg::*;
#(
   parameter int NUM_DIGITS   = 8,
   parameter int DWELL_CYCLES = 1,
   parameter int GAP_CYCLES   = 0,
   parameter bit HEX_EN       = 1'b0
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [4*NUM_DIGITS-1:0] digits_in,
   input  logic [NUM_DIGITS-1:0]   dp_in,
   input  logic [NUM_DIGITS-1:0]   en_in,
   input  logic                    lz_blank,
   input  logic                    load,
   output logic                    pending,
   output logic                    frame_done,
   output logic [7:0]              DISP,
   output logic [7:0]              cat
);

   localparam int         CNT_MAX    = (DWELL_CYCLES > GAP_CYCLES) ? DWELL_CYCLES : GAP_CYCLES;
   localparam int         CNT_W      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
   localparam int         GAP_LAST   = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
   localparam int         DWELL_LAST = DWELL_CYCLES - 1;
   localparam logic [2:0] IDX_LAST   = 3'(NUM_DIGITS - 1);

   state_e             r_state;
   logic [CNT_W-1:0]   r_cnt;
   logic [2:0]         r_idx;
   disp_buf_t          r_act;
   disp_buf_t          r_pend;
   logic               r_pending;
   logic               r_frame_done;
   logic [7:0]         r_disp;
   logic [7:0]         r_cat;

   state_e             w_state_nxt;
   logic [CNT_W-1:0]   w_cnt_nxt;
   logic [2:0]         w_idx_nxt;
   logic               w_frame_end;
   disp_buf_t          w_in;
   disp_buf_t          w_act_nxt;
   disp_buf_t          w_pend_nxt;
   logic               w_pending_nxt;
   logic [MAX_DIGITS-1:0] w_lz_sup;
   logic [3:0]         w_code;
   logic               w_dp;
   logic [7:0]         w_seg;
   logic [7:0]         w_disp_nxt;
   logic [7:0]         w_cat_nxt;

   // Unused upper digits are padded with en=0 so they can never light
   always_comb begin
      w_in      = BUF_CLEAR;
      w_in.code = 32'(digits_in);
      w_in.dp   = 8'(dp_in);
      w_in.en   = 8'(en_in);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_GAP;
         r_cnt   <= '0;
         r_idx   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_idx   <= w_idx_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_idx_nxt   = r_idx;
      w_frame_end = 1'b0;
      case (r_state)
         ST_GAP: begin
            if ((GAP_CYCLES == 0) || (r_cnt == CNT_W'(GAP_LAST))) begin
               w_state_nxt = ST_SHOW;
               w_cnt_nxt   = '0;
            end else begin
               w_cnt_nxt = r_cnt + 1'b1;
            end
         end
         default: begin
            if (r_cnt == CNT_W'(DWELL_LAST)) begin
               w_cnt_nxt   = '0;
               w_state_nxt = (GAP_CYCLES == 0) ? ST_SHOW : ST_GAP;
               if (r_idx == IDX_LAST) begin
                  w_idx_nxt   = '0;
                  w_frame_end = 1'b1;
               end else begin
                  w_idx_nxt = r_idx + 1'b1;
               end
            end else begin
               w_cnt_nxt = r_cnt + 1'b1;
            end
         end
      endcase
   end

   // A load coinciding with the commit bypasses the pending buffer entirely
   always_comb begin
      w_act_nxt     = r_act;
      w_pend_nxt    = r_pend;
      w_pending_nxt = r_pending;
      if (w_frame_end && load) begin
         w_act_nxt     = w_in;
         w_pending_nxt = 1'b0;
      end else begin
         if (w_frame_end && r_pending) begin
            w_act_nxt     = r_pend;
            w_pending_nxt = 1'b0;
         end
         if (load) begin
            w_pend_nxt    = w_in;
            w_pending_nxt = 1'b1;
         end
      end
   end

   // Disabled digits are invisible, so they neither blank nor end the zero run
   always_comb begin
      logic v_run;
      w_lz_sup = '0;
      v_run    = lz_blank;
      for (int i = MAX_DIGITS - 1; i >= 1; i--) begin
         if (w_act_nxt.en[i]) begin
            if ((w_act_nxt.code[4*i +: 4] == 4'd0) && !w_act_nxt.dp[i]) begin
               w_lz_sup[i] = v_run;
            end else begin
               v_run = 1'b0;
            end
         end
      end
   end

   assign w_code = w_act_nxt.code[4*w_idx_nxt +: 4];
   assign w_dp   = w_act_nxt.dp[w_idx_nxt];

   seg7_decode u_decode (
      .code   (w_code),
      .hex_en (HEX_EN),
      .dp     (w_dp),
      .seg    (w_seg)
   );

   // Outputs are computed for the slot being entered so they change on the entry edge
   always_comb begin
      w_disp_nxt = SEG_BLANK;
      w_cat_nxt  = CAT_OFF;
      if (w_state_nxt == ST_SHOW) begin
         w_cat_nxt = cat_select(w_idx_nxt);
         if (w_act_nxt.en[w_idx_nxt] && !w_lz_sup[w_idx_nxt]) begin
            w_disp_nxt = w_seg;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_act        <= BUF_CLEAR;
         r_pend       <= BUF_CLEAR;
         r_pending    <= 1'b0;
         r_frame_done <= 1'b0;
         r_disp       <= SEG_BLANK;
         r_cat        <= CAT_OFF;
      end else begin
         r_act        <= w_act_nxt;
         r_pend       <= w_pend_nxt;
         r_pending    <= w_pending_nxt;
         r_frame_done <= w_frame_end;
         r_disp       <= w_disp_nxt;
         r_cat        <= w_cat_nxt;
      end
   end

   assign pending    = r_pending;
   assign frame_done = r_frame_done;
   assign DISP       = r_disp;
   assign cat        = r_cat;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench: instance A uses the default timing, instance B uses a 2-cycle gap, 3-cycle dwell and hex glyphs.
module tb_seg7_scan_driver;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] digits_in;
   logic [7:0]  dp_in;
   logic [7:0]  en_in;
   logic        lz_blank;
   logic        load;

   logic        a_pending, a_fd, b_pending, b_fd;
   logic [7:0]  a_disp, a_cat, b_disp, b_cat;

   int checks   = 0;
   int failures = 0;

   logic [7:0] b_cat_exp  [10] = '{8'hFF, 8'hFF, 8'hFE, 8'hFE, 8'hFE, 8'hFF, 8'hFF, 8'hFD, 8'hFD, 8'hFD};
   logic [7:0] b_disp_exp [10] = '{8'h00, 8'h00, 8'h06, 8'h06, 8'h06, 8'h00, 8'h00, 8'h7C, 8'h7C, 8'h7C};

   always #5 clk = ~clk;

   seg7_scan_driver #(
      .NUM_DIGITS   (8),
      .DWELL_CYCLES (1),
      .GAP_CYCLES   (0),
      .HEX_EN       (1'b0)
   ) u_dut_a (
      .clk        (clk),
      .rst        (rst),
      .digits_in  (digits_in),
      .dp_in      (dp_in),
      .en_in      (en_in),
      .lz_blank   (lz_blank),
      .load       (load),
      .pending    (a_pending),
      .frame_done (a_fd),
      .DISP       (a_disp),
      .cat        (a_cat)
   );

   seg7_scan_driver #(
      .NUM_DIGITS   (8),
      .DWELL_CYCLES (3),
      .GAP_CYCLES   (2),
      .HEX_EN       (1'b1)
   ) u_dut_b (
      .clk        (clk),
      .rst        (rst),
      .digits_in  (digits_in),
      .dp_in      (dp_in),
      .en_in      (en_in),
      .lz_blank   (lz_blank),
      .load       (load),
      .pending    (b_pending),
      .frame_done (b_fd),
      .DISP       (b_disp),
      .cat        (b_cat)
   );

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_load(input logic [31:0] d, input logic [7:0] dp, input logic [7:0] en);
      digits_in = d;
      dp_in     = dp;
      en_in     = en;
      load      = 1'b1;
      step();
      load      = 1'b0;
   endtask

   task automatic wait_fd_a(input string tag);
      int n = 0;
      while (!a_fd && n < 100) begin
         step();
         n++;
      end
      check_val(tag, a_fd, 1);
   endtask

   task automatic wait_fd_b(input string tag);
      int n = 0;
      while (!b_fd && n < 200) begin
         step();
         n++;
      end
      check_val(tag, b_fd, 1);
   endtask

   // Called in the slot-0 cycle; walks all eight slots of instance A
   task automatic check_frame_a(input string tag, input logic [63:0] exp);
      logic [7:0] e_cat;
      for (int i = 0; i < 8; i++) begin
         if (i > 0) step();
         e_cat = ~(8'h01 << i);
         check_val({tag, "_cat"}, a_cat, e_cat);
         check_val({tag, "_disp"}, a_disp, exp[8*i +: 8]);
      end
   endtask

   initial begin
      int n;
      rst       = 1'b1;
      digits_in = '0;
      dp_in     = '0;
      en_in     = '0;
      lz_blank  = 1'b0;
      load      = 1'b0;
      repeat (3) step();

      check_val("rst_a_disp", a_disp, 8'h00);
      check_val("rst_a_cat", a_cat, 8'hFF);
      check_val("rst_a_pending", a_pending, 0);
      check_val("rst_a_fd", a_fd, 0);
      check_val("rst_b_cat", b_cat, 8'hFF);
      check_val("rst_b_disp", b_disp, 8'h00);

      rst = 1'b0;
      begin
         logic [7:0] e_cat;
         for (int i = 0; i < 8; i++) begin
            step();
            e_cat = ~(8'h01 << i);
            check_val("walk_cat", a_cat, e_cat);
            check_val("walk_disp", a_disp, 8'h00);
         end
      end
      step();
      check_val("walk_wrap_fd", a_fd, 1);
      check_val("walk_wrap_cat", a_cat, 8'hFE);

      lz_blank = 1'b1;
      do_load(32'h0000_0123, 8'h00, 8'hFF);
      check_val("t2_pending_set", a_pending, 1);
      wait_fd_a("t2_fd");
      check_val("t2_pending_clr", a_pending, 0);
      check_frame_a("lz_on", 64'h0000_0000_0006_5B4F);

      lz_blank = 1'b0;
      step();
      check_val("lz_off_fd", a_fd, 1);
      check_frame_a("lz_off", 64'h3F3F_3F3F_3F06_5B4F);

      lz_blank = 1'b1;
      step();
      step();
      do_load(32'h0000_0005, 8'h00, 8'hFF);
      check_val("t3_pending_1", a_pending, 1);
      do_load(32'h0000_0007, 8'h00, 8'hFF);
      check_val("t3_pending_2", a_pending, 1);
      wait_fd_a("t3_fd");
      check_val("t3_pending_clr", a_pending, 0);
      check_frame_a("last_wins", 64'h0000_0000_0000_0007);

      do_load(32'h0000_0009, 8'h00, 8'hFF);
      check_val("t4_fd", a_fd, 1);
      check_val("t4_pending", a_pending, 0);
      check_frame_a("commit_load", 64'h0000_0000_0000_006F);

      do_load(32'h0000_00B1, 8'h00, 8'hFF);
      check_frame_a("hex_off", 64'h0000_0000_0000_0006);

      do_load(32'h0000_0005, 8'h02, 8'hFF);
      check_frame_a("dp_keep", 64'h0000_0000_0000_BF6D);

      do_load(32'h0000_0088, 8'h01, 8'hFE);
      check_frame_a("en_blank", 64'h0000_0000_0000_7F00);

      do_load(32'h0000_0000, 8'h10, 8'hFF);
      check_frame_a("lz_dp", 64'h0000_00BF_3F3F_3F3F);

      do_load(32'h0000_00B1, 8'h00, 8'hFF);
      check_val("b_pending_set", b_pending, 1);
      wait_fd_b("b_fd");
      check_val("b_pending_clr", b_pending, 0);
      for (int k = 0; k < 10; k++) begin
         if (k > 0) step();
         check_val("b_slot_cat", b_cat, b_cat_exp[k]);
         check_val("b_slot_disp", b_disp, b_disp_exp[k]);
      end
      n = 9;
      while (!b_fd && n < 100) begin
         step();
         n++;
      end
      check_val("b_period", n, 40);

      step();
      step();
      check_val("b_mid_show_cat", b_cat, 8'hFE);
      do_load(32'h0000_0042, 8'h00, 8'hFF);
      check_val("b_pending_pre_rst", b_pending, 1);
      check_val("a_pending_pre_rst", a_pending, 1);
      rst = 1'b1;
      step();
      check_val("mid_rst_b_cat", b_cat, 8'hFF);
      check_val("mid_rst_b_disp", b_disp, 8'h00);
      check_val("mid_rst_b_pending", b_pending, 0);
      check_val("mid_rst_b_fd", b_fd, 0);
      check_val("mid_rst_a_cat", a_cat, 8'hFF);
      check_val("mid_rst_a_pending", a_pending, 0);
      rst = 1'b0;
      step();
      check_frame_a("dark_after_rst", 64'h0);
      check_val("dark_pending", a_pending, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
